song_sequencer: RTL

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/song_sequencer.sv
// song_sequencer: steps through a per-song note table in a synchronous ROM.
// For each entry it registers the note code and plays it for a number of
// duration units, each unit being TICK_DIV clock cycles long.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; busy low
// S_FETCH | rom_addr presented to the ROM
// S_WAIT  | ROM read latency; the edge leaving WAIT is the load decision
// S_PLAY  | unit counter running; beat on every wrap
module song_sequencer #(
  parameter int unsigned TICK_DIV = 3375000,
  parameter int unsigned IDX_W    = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       song,
  input  logic             abort,
  output logic [IDX_W+1:0] rom_addr,
  input  logic [11:0]      rom_data,
  output logic [5:0]       note,
  output logic             note_valid,
  output logic             note_start,
  output logic             beat,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] UNIT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [5:0] CODE_END = 6'h3F;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_PLAY} state_e;

  state_e             state_q;
  logic [1:0]         song_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_d;
  logic [IDX_W+1:0]   rom_addr_q;
  logic [5:0]         note_q;
  logic               note_valid_q;
  logic               note_start_q;
  logic               beat_q;
  logic               done_q;
  logic [CNT_W-1:0]   unit_q;
  logic [5:0]         dur_q;
  logic [5:0]         rom_code;
  logic [5:0]         rom_dur;

  assign idx_d    = idx_q + 1'b1;
  assign rom_code = rom_data[11:6];
  // A zero duration still plays for one unit.
  assign rom_dur  = (rom_data[5:0] == 6'd0) ? 6'd1 : rom_data[5:0];

  // Sequencer FSM with all outputs registered; abort outranks start, and
  // start restarts from any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      song_q       <= 2'd0;
      idx_q        <= '0;
      rom_addr_q   <= '0;
      note_q       <= 6'd0;
      note_valid_q <= 1'b0;
      note_start_q <= 1'b0;
      beat_q       <= 1'b0;
      done_q       <= 1'b0;
      unit_q       <= '0;
      dur_q        <= 6'd0;
    end else begin
      note_start_q <= 1'b0;
      beat_q       <= 1'b0;
      done_q       <= 1'b0;
      if (abort) begin
        state_q      <= S_IDLE;
        note_valid_q <= 1'b0;
        unit_q       <= '0;
        dur_q        <= 6'd0;
      end else if (start) begin
        state_q      <= S_FETCH;
        song_q       <= song;
        idx_q        <= '0;
        rom_addr_q   <= {song, {IDX_W{1'b0}}};
        note_valid_q <= 1'b0;
        unit_q       <= '0;
        dur_q        <= 6'd0;
      end else begin
        case (state_q)
          S_IDLE: begin
            state_q <= S_IDLE;
          end
          S_FETCH: begin
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            if (rom_code == CODE_END) begin
              state_q      <= S_IDLE;
              note_valid_q <= 1'b0;
              done_q       <= 1'b1;
            end else begin
              state_q      <= S_PLAY;
              note_q       <= rom_code;
              note_valid_q <= (rom_code != 6'd0);
              note_start_q <= 1'b1;
              dur_q        <= rom_dur;
              unit_q       <= '0;
            end
          end
          S_PLAY: begin
            if (unit_q == UNIT_LAST) begin
              unit_q <= '0;
              beat_q <= 1'b1;
              if (dur_q == 6'd1) begin
                dur_q <= 6'd0;
                if (&idx_q) begin
                  // Table exhausted: finish rather than wrap to entry 0.
                  state_q      <= S_IDLE;
                  note_valid_q <= 1'b0;
                  done_q       <= 1'b1;
                end else begin
                  state_q    <= S_FETCH;
                  idx_q      <= idx_d;
                  rom_addr_q <= {song_q, idx_d};
                end
              end else begin
                dur_q <= dur_q - 1'b1;
              end
            end else begin
              unit_q <= unit_q + 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign rom_addr   = rom_addr_q;
  assign note       = note_q;
  assign note_valid = note_valid_q;
  assign note_start = note_start_q;
  assign beat       = beat_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);

endmodule
